// File: rtl/score_text_gen_pkg.sv
// Shared constants, state types and helpers for the score-screen text generator.
// Holds ASCII codes, row/column layout, FSM state types and BCD sizing.
package score_text_gen_pkg;

  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_COLON = 7'h3a;
  localparam logic [6:0] CH_ZERO  = 7'h30;
  localparam logic [6:0] CH_ONE   = 7'h31;
  localparam logic [6:0] CH_DASH  = 7'h2d;
  localparam logic [6:0] CH_QMARK = 7'h3f;

  // Win line sits at N_PLAYERS + ROW_WIN_OFS.
  localparam int unsigned ROW_TITLE   = 0;
  localparam int unsigned ROW_WIN_OFS = 1;

  localparam int unsigned TXT_LEN     = 6;
  localparam int unsigned COL_PNUM    = 6;
  localparam int unsigned COL_PCOLON  = 7;
  localparam int unsigned COL_DIGIT0  = 8;
  localparam int unsigned COL_WCOLON  = 6;
  localparam int unsigned COL_WNUM    = 7;
  localparam int unsigned COL_WSUFFIX = 8;
  localparam int unsigned WSUFFIX_LEN = 4;

  localparam logic [47:0] TXT_SCORE  = "SCORE:";
  localparam logic [47:0] TXT_PLAYER = "Player";
  localparam logic [31:0] TXT_WIN    = "-win";

  typedef enum logic [1:0] {CV_IDLE, CV_LOAD, CV_SHIFT, CV_STORE} conv_state_t;
  typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_DONE} sweep_state_t;

  // Nibbles needed to hold 2^w-1 in BCD (0.3 underestimates log10(2) safely for w < 97).
  function automatic int unsigned bcd_nibbles(input int unsigned w, input int unsigned d);
    int unsigned n;
    n = (w * 3) / 10 + 1;
    return (n > d) ? n : d;
  endfunction

  function automatic logic [6:0] txt_char(input logic [47:0] s, input int unsigned len,
                                          input int unsigned i);
    return s[8*(len-1-i) +: 7];
  endfunction

endpackage

// File: rtl/score_text_gen_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter with start/done handshake.
// Results at or above 10^DIGITS saturate to all nines.
module bin2bcd_seq
  import score_text_gen_pkg::*;
#(
  parameter int unsigned SCORE_W = 14,
  parameter int unsigned DIGITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits
);

  localparam int unsigned BCD_N = bcd_nibbles(SCORE_W, DIGITS);
  localparam int unsigned CNT_W = $clog2(SCORE_W);

  conv_state_t          state, state_next;
  logic [4*BCD_N-1:0]   bcd, bcd_adj;
  logic [SCORE_W-1:0]   sr;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < BCD_N; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  always_comb begin
    state_next = state;
    case (state)
      CV_IDLE:  if (start) state_next = CV_LOAD;
      CV_LOAD:  state_next = CV_SHIFT;
      CV_SHIFT: if (cnt == CNT_W'(SCORE_W - 1)) state_next = CV_STORE;
      CV_STORE: state_next = start ? CV_LOAD : CV_IDLE;
      default:  state_next = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CV_IDLE;
      bcd   <= '0;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      case (state)
        CV_LOAD: begin
          bcd <= '0;
          sr  <= bin;
          cnt <= '0;
        end
        CV_SHIFT: begin
          bcd <= {bcd_adj[4*BCD_N-2:0], sr[SCORE_W-1]};
          sr  <= {sr[SCORE_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  generate
    if (BCD_N > DIGITS) begin : g_ovf
      assign ovf = |bcd[4*BCD_N-1:4*DIGITS];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

  assign done   = (state == CV_STORE);
  assign digits = ovf ? {DIGITS{4'h9}} : bcd[4*DIGITS-1:0];

endmodule

// File: rtl/score_text_gen.sv
// Score-screen text generator: maps {row,col} to a char code, showing decimal scores
// converted per frame and committed tear-free at frame_start.
module score_text_gen
  import score_text_gen_pkg::*;
#(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned SCORE_W   = 14,
  parameter int unsigned DIGITS    = 5,
  parameter int unsigned COL_W     = 4,
  parameter int unsigned ROW_W     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PLAYERS*SCORE_W-1:0]   scores,
  input  logic [2:0]                     winner,
  input  logic                           winner_valid,
  input  logic                           frame_start,
  input  logic [ROW_W+COL_W-1:0]         char_xy,
  output logic [6:0]                     char_code_out,
  output logic                           busy
);

  localparam int unsigned IDX_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

  sweep_state_t          state, state_next;
  logic [IDX_W-1:0]      idx;
  logic                  staged_ok;
  logic [SCORE_W-1:0]    snap      [N_PLAYERS];
  logic [4*DIGITS-1:0]   staged    [N_PLAYERS];
  logic [4*DIGITS-1:0]   displayed [N_PLAYERS];

  logic                  accept, last;
  logic                  conv_start, conv_done;
  logic [SCORE_W-1:0]    conv_bin;
  logic [4*DIGITS-1:0]   conv_digits;

  bin2bcd_seq #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_conv (
    .clk    (clk),
    .rst    (rst),
    .start  (conv_start),
    .bin    (conv_bin),
    .done   (conv_done),
    .digits (conv_digits)
  );

  assign last = (32'(idx) == N_PLAYERS - 1);
  assign busy = (state != SW_IDLE);

  always_comb begin
    conv_bin = '0;
    for (int unsigned k = 0; k < N_PLAYERS; k++)
      if (32'(idx) == k) conv_bin = snap[k];
  end

  // The next player's LOAD is requested during STORE so players run back to back.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    conv_start = 1'b0;
    case (state)
      SW_IDLE: if (frame_start) begin
        accept     = 1'b1;
        conv_start = 1'b1;
        state_next = SW_RUN;
      end
      SW_RUN: if (conv_done) begin
        if (last) state_next = SW_DONE;
        else      conv_start = 1'b1;
      end
      SW_DONE: state_next = SW_IDLE;
      default: state_next = SW_IDLE;
    endcase
  end

  // Character lookup from the displayed bank.
  int unsigned         lk_r, lk_c, lk_d;
  logic [4*DIGITS-1:0] lk_dv;
  logic [3:0]          lk_nib;
  logic                lk_hi_zero;
  logic [6:0]          char_next;

  always_comb begin
    lk_r       = 32'(char_xy[ROW_W+COL_W-1:COL_W]);
    lk_c       = 32'(char_xy[COL_W-1:0]);
    lk_d       = 0;
    lk_dv      = '0;
    lk_nib     = '0;
    lk_hi_zero = 1'b1;
    char_next  = CH_SPACE;
    for (int unsigned k = 0; k < N_PLAYERS; k++)
      if (lk_r == k + 1) lk_dv = displayed[k];
    if (lk_r == ROW_TITLE) begin
      if (lk_c < TXT_LEN) char_next = txt_char(TXT_SCORE, TXT_LEN, lk_c);
    end else if (lk_r <= N_PLAYERS) begin
      if (lk_c < TXT_LEN) char_next = txt_char(TXT_PLAYER, TXT_LEN, lk_c);
      else if (lk_c == COL_PNUM) char_next = CH_ONE + 7'(lk_r - 1);
      else if (lk_c == COL_PCOLON) char_next = CH_COLON;
      else if (lk_c >= COL_DIGIT0 && lk_c < COL_DIGIT0 + DIGITS) begin
        lk_d = DIGITS - 1 - (lk_c - COL_DIGIT0);
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (i >= lk_d && lk_dv[4*i +: 4] != 4'd0) lk_hi_zero = 1'b0;
          if (i == lk_d) lk_nib = lk_dv[4*i +: 4];
        end
        char_next = (lk_hi_zero && lk_d != 0) ? CH_SPACE : CH_ZERO + {3'b000, lk_nib};
      end
    end else if (lk_r == N_PLAYERS + ROW_WIN_OFS && winner_valid) begin
      if (lk_c < TXT_LEN) char_next = txt_char(TXT_PLAYER, TXT_LEN, lk_c);
      else if (lk_c == COL_WCOLON) char_next = CH_COLON;
      else if (lk_c == COL_WNUM)
        char_next = (32'(winner) < N_PLAYERS) ? CH_ONE + {4'b0000, winner} : CH_QMARK;
      else if (lk_c >= COL_WSUFFIX && lk_c < COL_WSUFFIX + WSUFFIX_LEN)
        char_next = txt_char({16'h0000, TXT_WIN}, WSUFFIX_LEN, lk_c - COL_WSUFFIX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SW_IDLE;
      idx           <= '0;
      staged_ok     <= 1'b0;
      char_code_out <= '0;
      for (int unsigned k = 0; k < N_PLAYERS; k++) begin
        snap[k]      <= '0;
        staged[k]    <= '0;
        displayed[k] <= '0;
      end
    end else begin
      state         <= state_next;
      char_code_out <= char_next;
      if (accept) begin
        idx <= '0;
        for (int unsigned k = 0; k < N_PLAYERS; k++)
          snap[k] <= scores[k*SCORE_W +: SCORE_W];
        if (staged_ok) begin
          for (int unsigned k = 0; k < N_PLAYERS; k++)
            displayed[k] <= staged[k];
          staged_ok <= 1'b0;
        end
      end
      if (conv_done) begin
        for (int unsigned k = 0; k < N_PLAYERS; k++)
          if (32'(idx) == k) staged[k] <= conv_digits;
        if (!last) idx <= idx + 1'b1;
      end
      if (state == SW_DONE) staged_ok <= 1'b1;
    end
  end

endmodule

// File: tb/tb_score_text_gen.sv
// Self-checking bench for score_text_gen: a 5-digit and a saturating 4-digit build
// compared against a string-level model of the score screen.
module tb_score_text_gen;

  localparam int unsigned N    = 2;
  localparam int unsigned SW   = 14;
  localparam int unsigned COLW = 4;
  localparam int unsigned ROWW = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N*SW-1:0]      scores = '0;
  logic [2:0]           winner = '0;
  logic                 winner_valid = 1'b0;
  logic                 frame_start = 1'b0;
  logic [ROWW+COLW-1:0] char_xy = '0;
  logic [6:0]           code5, code4;
  logic                 busy5, busy4;

  always #5 clk = ~clk;

  score_text_gen #(.N_PLAYERS(N), .SCORE_W(SW), .DIGITS(5), .COL_W(COLW), .ROW_W(ROWW)) dut (
    .clk(clk), .rst(rst), .scores(scores), .winner(winner), .winner_valid(winner_valid),
    .frame_start(frame_start), .char_xy(char_xy), .char_code_out(code5), .busy(busy5));

  score_text_gen #(.N_PLAYERS(N), .SCORE_W(SW), .DIGITS(4), .COL_W(COLW), .ROW_W(ROWW)) dut4 (
    .clk(clk), .rst(rst), .scores(scores), .winner(winner), .winner_valid(winner_valid),
    .frame_start(frame_start), .char_xy(char_xy), .char_code_out(code4), .busy(busy4));

  int          errors = 0;
  int          checks = 0;
  int unsigned sc_m[N], snap_m[N], staged_m[N], disp_m[N];
  bit          staged_ok_m = 0;
  logic [6:0]  got5, got4;
  int          cyc;

  // Reference: build the whole row as a string, then pick the column.
  function automatic logic [6:0] model_char(input int unsigned r, input int unsigned c,
                                            input int unsigned nd);
    string s, num;
    int unsigned v, lim;
    byte b;
    s = "";
    lim = 1;
    repeat (nd) lim = lim * 10;
    if (r == 0) s = "SCORE:";
    else if (r <= N) begin
      v = disp_m[r-1];
      if (v > lim - 1) v = lim - 1;
      num = $sformatf("%0d", v);
      while (num.len() < int'(nd)) num = {" ", num};
      s = {$sformatf("Player%0d:", r), num};
    end else if (r == N + 1 && winner_valid) begin
      if (winner < N) s = $sformatf("Player:%0d-win", winner + 1);
      else s = "Player:?-win";
    end
    if (int'(c) < s.len()) begin
      b = s[c];
      return b[6:0];
    end
    return 7'h20;
  endfunction

  task automatic set_scores;
    for (int k = 0; k < N; k++) scores[k*SW +: SW] = sc_m[k][SW-1:0];
  endtask

  task automatic read_cell(input int unsigned r, input int unsigned c);
    @(posedge clk); #1;
    char_xy = {ROWW'(r), COLW'(c)};
    @(posedge clk); #1;
    got5 = code5;
    got4 = code4;
  endtask

  task automatic frame_pulse;
    if (staged_ok_m) begin
      disp_m = staged_m;
      staged_ok_m = 0;
    end
    snap_m = sc_m;
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy5 === 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy5 !== 1'b0) begin
      checks++; errors++;
      $display("FAIL sweep_timeout busy=%b required=0", busy5);
    end
    staged_m = snap_m;
    staged_ok_m = 1;
  endtask

  task automatic do_frame(output int n);
    frame_pulse();
    wait_idle(n);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if (code5 !== 7'h00) begin errors++; $display("FAIL reset_code got=%h required=00", code5); end
    if (busy5 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy5); end
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin sc_m[k] = 0; disp_m[k] = 0; end
    read_cell(0, 0);
    checks++;
    if (got5 !== 7'h53) begin errors++; $display("FAIL reset_S got=%h required=53", got5); end
    read_cell(0, 5);
    checks++;
    if (got5 !== 7'h3a) begin errors++; $display("FAIL reset_colon got=%h required=3a", got5); end
    read_cell(1, 12);
    checks++;
    if (got5 !== 7'h30) begin errors++; $display("FAIL reset_lsd got=%h required=30", got5); end
    read_cell(1, 8);
    checks += 2;
    if (got5 !== 7'h20) begin errors++; $display("FAIL reset_msd got=%h required=20", got5); end
    if (busy5 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL reset_busy_after got=%b%b required=00", busy5, busy4);
    end
  endtask

  task automatic test_basic;
    logic [6:0] exp1 [5];
    exp1 = '{7'h20, 7'h31, 7'h32, 7'h33, 7'h34};
    sc_m[0] = 1234; sc_m[1] = 0;
    set_scores();
    do_frame(cyc);
    checks++;
    if (cyc != (SW + 2) * N + 1) begin
      errors++; $display("FAIL sweep_len got=%0d required=%0d", cyc, (SW + 2) * N + 1);
    end
    do_frame(cyc);
    for (int c = 0; c < 5; c++) begin
      read_cell(1, 8 + c);
      checks++;
      if (got5 !== exp1[c]) begin errors++; $display("FAIL basic_r1 c%0d got=%h required=%h", 8 + c, got5, exp1[c]); end
      read_cell(2, 8 + c);
      checks++;
      if (got5 !== ((c == 4) ? 7'h30 : 7'h20)) begin
        errors++; $display("FAIL basic_r2 c%0d got=%h required=%h", 8 + c, got5, (c == 4) ? 7'h30 : 7'h20);
      end
    end
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 16; c++) begin
        read_cell(r, c);
        checks += 2;
        if (got5 !== model_char(r, c, 5)) begin errors++; $display("FAIL basic_d5 r%0d c%0d got=%h required=%h", r, c, got5, model_char(r, c, 5)); end
        if (got4 !== model_char(r, c, 4)) begin errors++; $display("FAIL basic_d4 r%0d c%0d got=%h required=%h", r, c, got4, model_char(r, c, 4)); end
      end
  endtask

  task automatic test_max;
    logic [6:0] exp5 [5];
    exp5 = '{7'h31, 7'h36, 7'h33, 7'h38, 7'h33};
    sc_m[0] = 16383; sc_m[1] = 10000;
    set_scores();
    do_frame(cyc);
    do_frame(cyc);
    for (int c = 0; c < 5; c++) begin
      read_cell(1, 8 + c);
      checks++;
      if (got5 !== exp5[c]) begin errors++; $display("FAIL max_d5 c%0d got=%h required=%h", 8 + c, got5, exp5[c]); end
      if (c < 4) begin
        checks++;
        if (got4 !== 7'h39) begin errors++; $display("FAIL sat_d4 c%0d got=%h required=39", 8 + c, got4); end
      end
    end
    for (int unsigned c = 8; c < 14; c++) begin
      read_cell(2, c);
      checks += 2;
      if (got5 !== model_char(2, c, 5)) begin errors++; $display("FAIL max_r2_d5 c%0d got=%h required=%h", c, got5, model_char(2, c, 5)); end
      if (got4 !== model_char(2, c, 4)) begin errors++; $display("FAIL max_r2_d4 c%0d got=%h required=%h", c, got4, model_char(2, c, 4)); end
    end
  endtask

  task automatic test_busy_ignore;
    sc_m[0] = 111; sc_m[1] = 222;       // A
    set_scores();
    do_frame(cyc);
    sc_m[0] = 3333; sc_m[1] = 44;       // B
    set_scores();
    frame_pulse();                      // commits A, snapshots B
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (busy5 !== 1'b1) begin errors++; $display("FAIL busy_mid got=%b required=1", busy5); end
    sc_m[0] = 9; sc_m[1] = 16000;       // C
    set_scores();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    checks++;
    if (busy5 !== 1'b1) begin errors++; $display("FAIL busy_no_restart got=%b required=1", busy5); end
    for (int unsigned c = 8; c < 13; c++) begin
      read_cell(1, c);
      checks++;
      if (got5 !== model_char(1, c, 5)) begin errors++; $display("FAIL busy_hold c%0d got=%h required=%h", c, got5, model_char(1, c, 5)); end
    end
    wait_idle(cyc);
    for (int pass = 0; pass < 3; pass++) begin
      for (int unsigned r = 1; r <= N; r++)
        for (int unsigned c = 8; c < 13; c++) begin
          read_cell(r, c);
          checks += 2;
          if (got5 !== model_char(r, c, 5)) begin errors++; $display("FAIL busy_seq p%0d r%0d c%0d got=%h required=%h", pass, r, c, got5, model_char(r, c, 5)); end
          if (got4 !== model_char(r, c, 4)) begin errors++; $display("FAIL busy_seq4 p%0d r%0d c%0d got=%h required=%h", pass, r, c, got4, model_char(r, c, 4)); end
        end
      do_frame(cyc);
    end
  endtask

  task automatic test_winner;
    int wins [4];
    wins = '{1, 5, 2, 0};
    winner_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      winner = 3'(wins[w]);
      for (int unsigned c = 0; c < 16; c++) begin
        read_cell(N + 1, c);
        checks++;
        if (got5 !== model_char(N + 1, c, 5)) begin errors++; $display("FAIL win w%0d c%0d got=%h required=%h", wins[w], c, got5, model_char(N + 1, c, 5)); end
      end
    end
    winner = 3'd1;
    read_cell(N + 1, 7);
    checks++;
    if (got5 !== 7'h32) begin errors++; $display("FAIL win_digit got=%h required=32", got5); end
    winner = 3'd5;
    read_cell(N + 1, 7);
    checks++;
    if (got5 !== 7'h3f) begin errors++; $display("FAIL win_qmark got=%h required=3f", got5); end
    winner_valid = 1'b0;
    for (int unsigned c = 0; c < 16; c++) begin
      read_cell(N + 1, c);
      checks++;
      if (got5 !== 7'h20) begin errors++; $display("FAIL win_off c%0d got=%h required=20", c, got5); end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < N; k++)
        sc_m[k] = $urandom_range(0, (1 << $urandom_range(1, SW)) - 1);
      winner_valid = 1'($urandom_range(0, 1));
      winner = 3'($urandom_range(0, 7));
      set_scores();
      do_frame(cyc);
      do_frame(cyc);
      for (int unsigned r = 0; r < 16; r++)
        for (int unsigned c = 0; c < 16; c++) begin
          read_cell(r, c);
          checks += 2;
          if (got5 !== model_char(r, c, 5)) begin errors++; $display("FAIL rand_d5 i%0d r%0d c%0d got=%h required=%h", it, r, c, got5, model_char(r, c, 5)); end
          if (got4 !== model_char(r, c, 4)) begin errors++; $display("FAIL rand_d4 i%0d r%0d c%0d got=%h required=%h", it, r, c, got4, model_char(r, c, 4)); end
        end
    end
    winner_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    sc_m[0] = 4321; sc_m[1] = 87;
    set_scores();
    do_frame(cyc);
    do_frame(cyc);
    frame_pulse();
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy5 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b%b required=00", busy5, busy4); end
    rst = 1'b0;
    for (int k = 0; k < N; k++) disp_m[k] = 0;
    staged_ok_m = 0;
    for (int unsigned r = 1; r <= N; r++)
      for (int unsigned c = 8; c < 13; c++) begin
        read_cell(r, c);
        checks++;
        if (got5 !== ((c == 12) ? 7'h30 : 7'h20)) begin
          errors++; $display("FAIL rst_mid_cell r%0d c%0d got=%h required=%h", r, c, got5, (c == 12) ? 7'h30 : 7'h20);
        end
      end
    do_frame(cyc);                      // first frame after reset: no commit
    read_cell(1, 9);
    checks++;
    if (got5 !== model_char(1, 9, 5)) begin errors++; $display("FAIL rst_nocommit got=%h required=%h", got5, model_char(1, 9, 5)); end
    do_frame(cyc);
    for (int unsigned c = 8; c < 13; c++) begin
      read_cell(1, c);
      checks++;
      if (got5 !== model_char(1, c, 5)) begin errors++; $display("FAIL rst_recommit c%0d got=%h required=%h", c, got5, model_char(1, c, 5)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_busy_ignore();
    test_winner();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
